// File: rtl/io_in_pkg.sv
// Shared constants and helpers for the board input conditioning block.
package io_in_pkg;

  localparam int unsigned IO_WIDTH         = 32;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  // Counter width is max(1, clog2(cycles)) so a 1- or 2-cycle debounce still has a real register.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button bit: 2-flop synchroniser, stability counter, stable value and
// optional rising-edge press pulse (compiled in with IO_BTN_EDGE_EN).
module debounce_bit
  import io_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable_q <= sync[1];
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign stable = stable_q;

`ifdef IO_BTN_EDGE_EN
  logic stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_d <= 1'b0;
    else     stable_d <= stable_q;
  end

  // High for the single cycle in which stable is newly 1 and its delayed copy still 0.
  assign press = stable_q & ~stable_d;
`else
  assign press = 1'b0;
`endif

endmodule

// File: rtl/io_in_cond.sv
// Board switch/button conditioning: synchronised switches, debounced buttons
// and optional press pulses (macro IO_BTN_EDGE_EN).
module io_in_cond
  import io_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [IO_WIDTH-1:0] i_sw_raw,
  input  logic [IO_WIDTH-1:0] i_btn_raw,
  output logic [IO_WIDTH-1:0] o_io_sw,
  output logic [IO_WIDTH-1:0] o_io_btn,
  output logic [IO_WIDTH-1:0] o_btn_press
);

  logic [IO_WIDTH-1:0] sw_s1;
  logic [IO_WIDTH-1:0] sw_s2;
  logic [IO_WIDTH-1:0] btn_pol;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_sw_raw;
      sw_s2 <= sw_s1;
    end
  end

  assign o_io_sw = sw_s2;
  assign btn_pol = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;

  for (genvar i = 0; i < IO_WIDTH; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (i_clk),
      .rst   (i_rst),
      .raw   (btn_pol[i]),
      .stable(o_io_btn[i]),
      .press (o_btn_press[i])
    );
  end

endmodule

// File: tb/tb_io_in_cond.sv
// Scoreboard bench for io_in_cond with DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1.
module tb_io_in_cond;

  typedef struct {
    logic [31:0] sw;
    logic [31:0] btn;
    logic [31:0] press;
    string       nm;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_sw_raw = '0;
  logic [31:0] i_btn_raw = '1;
  logic [31:0] o_io_sw, o_io_btn, o_btn_press;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  io_in_cond #(
    .DEBOUNCE_CYCLES(4),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sw_raw   (i_sw_raw),
    .i_btn_raw  (i_btn_raw),
    .o_io_sw    (o_io_sw),
    .o_io_btn   (o_io_btn),
    .o_btn_press(o_btn_press)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] pe(input logic [31:0] x);
`ifdef IO_BTN_EDGE_EN
    return x;
`else
    return (x & 32'h0);
`endif
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string nm, input logic [31:0] sw, input logic [31:0] btn,
                         input logic [31:0] press);
    cmp({nm, ".sw"}, o_io_sw, sw);
    cmp({nm, ".btn"}, o_io_btn, btn);
    cmp({nm, ".press"}, o_btn_press, press);
  endtask

  // Drive one cycle's raw inputs at the negedge, queue the outputs expected after the next edge.
  task automatic cyc(input logic [31:0] sw_raw, input logic [31:0] btn_raw,
                     input logic [31:0] e_sw, input logic [31:0] e_btn,
                     input logic [31:0] e_press, input string nm);
    exp_t e;
    i_sw_raw  = sw_raw;
    i_btn_raw = btn_raw;
    e.sw = e_sw; e.btn = e_btn; e.press = e_press; e.nm = nm;
    sb.push_back(e);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Monitor: every output cycle is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp_all(e.nm, e.sw, e.btn, e.press);
      end
    end
  end

  initial begin
    logic [31:0] b;
    int unsigned wait_cnt;

    // Reset asserted asynchronously, checked before any clock edge.
    i_sw_raw  = 32'hDEAD_BEEF;
    i_btn_raw = 32'h0;
    #1 i_rst = 1'b1;
    #1 cmp_all("rst_async", '0, '0, '0);
    @(negedge i_clk);
    for (int k = 0; k < 3; k++) cyc(32'hDEAD_BEEF, 32'h0, '0, '0, '0, "rst_held");
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) cyc(32'h0, '1, '0, '0, '0, "idle");

    // Switch path: two-edge latency.
    cyc(32'hA5, '1, 32'h0,  '0, '0, "sw_e1");
    cyc(32'hA5, '1, 32'hA5, '0, '0, "sw_e2");
    cyc(32'hA5, '1, 32'hA5, '0, '0, "sw_e3");

    // Clean press and release of bit 0.
    for (int k = 1; k <= 10; k++)
      cyc(32'hA5, 32'hFFFF_FFFE, 32'hA5, (k >= 6) ? 32'h1 : 32'h0,
          pe((k == 6) ? 32'h1 : 32'h0), $sformatf("press0_e%0d", k));
    for (int k = 1; k <= 10; k++)
      cyc(32'hA5, 32'hFFFF_FFFF, 32'hA5, (k >= 6) ? 32'h0 : 32'h1, '0,
          $sformatf("rel0_e%0d", k));

    // Bit 3 bounces in 2-cycle runs for 12 cycles, then held pressed from edge 13.
    for (int k = 1; k <= 20; k++) begin
      b = ((k >= 13) || (((k - 1) / 2) % 2 == 0)) ? ~32'h8 : 32'hFFFF_FFFF;
      cyc(32'hA5, b, 32'hA5, (k >= 18) ? 32'h8 : 32'h0,
          pe((k == 18) ? 32'h8 : 32'h0), $sformatf("bounce3_e%0d", k));
    end

    // Bit 1 pressed (bit 3 still pressed); reset from edge 4 to edge 6.
    for (int k = 1; k <= 3; k++)
      cyc(32'hA5, ~32'hA, 32'hA5, 32'h8, '0, $sformatf("rstmid_e%0d", k));
    i_rst = 1'b1;
    #1 cmp_all("rstmid_async", '0, '0, '0);
    for (int k = 4; k <= 6; k++)
      cyc(32'hA5, ~32'hA, '0, '0, '0, $sformatf("rstmid_e%0d", k));
    i_rst = 1'b0;
    for (int k = 7; k <= 14; k++)
      cyc(32'hA5, ~32'hA, (k >= 8) ? 32'hA5 : 32'h0, (k >= 12) ? 32'hA : 32'h0,
          pe((k == 12) ? 32'hA : 32'h0), $sformatf("rstmid_e%0d", k));

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(negedge i_clk);
      wait_cnt++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
